// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and memory-wait controller for a classic 5-stage pipeline.
// Produces per-register stall/flush controls, drives the DRAM request, detects
// a memory timeout (sticky fault) and counts the cycles the PC was held.
module pipe_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_wR,
    input  logic        ex_is_load,
    input  logic        ex_branch_taken,
    input  logic        mem_access,
    input  logic        dram_ack,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        idex_stall,
    output logic        exmem_stall,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        memwb_flush,
    output logic        dram_req,
    output logic        fault,
    output logic [15:0] stall_cycles
);

    // Wait counter only has to reach TIMEOUT-1, so size it to that.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] FAULT    = 2'd2;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [CW-1:0] waitCnt_q;
    logic [CW-1:0] waitCnt_d;
    logic          fault_q;
    logic          fault_d;
    logic [15:0]   stallCnt_q;
    logic [15:0]   stallCnt_d;

    logic          loadUse;
    logic          memWait;
    logic          memHold;
    logic          hazardEval;
    logic          faultHold;
    logic          reqRaw;
    logic [3:0]    stallRaw;
    logic [2:0]    flushRaw;

    // Hazard terms: a load in EX feeding a register the ID instruction reads,
    // and a memory access that has not been acknowledged this cycle.
    always_comb begin
        loadUse = ex_is_load && (ex_wR != 5'd0) &&
                  ((id_use_rs1 && (id_rs1 == ex_wR)) ||
                   (id_use_rs2 && (id_rs2 == ex_wR)));
        memWait = mem_access && !dram_ack;
    end

    // Sequencing: decide whether the pipe is frozen for memory, whether the
    // branch/load-use rules apply this cycle, and where the FSM goes next.
    always_comb begin
        state_d    = state_q;
        waitCnt_d  = waitCnt_q;
        fault_d    = fault_q;
        memHold    = 1'b0;
        hazardEval = 1'b0;
        faultHold  = 1'b0;
        reqRaw     = 1'b0;
        case (state_q)
            RUN: begin
                reqRaw = mem_access;
                if (memWait) begin
                    memHold   = 1'b1;
                    state_d   = MEM_WAIT;
                    waitCnt_d = '0;
                end else begin
                    hazardEval = 1'b1;
                end
            end
            MEM_WAIT: begin
                reqRaw = 1'b1;
                if (!dram_ack) begin
                    memHold = 1'b1;
                    if (waitCnt_q == WAIT_LAST) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end else begin
                        waitCnt_d = waitCnt_q + CW'(1);
                    end
                end else begin
                    hazardEval = 1'b1;
                    state_d    = RUN;
                    waitCnt_d  = '0;
                end
            end
            FAULT: begin
                faultHold = 1'b1;
                fault_d   = 1'b1;
            end
            default: begin
                state_d   = RUN;
                waitCnt_d = '0;
            end
        endcase
    end

    // Control decode: memory freeze dominates, then a taken branch squashes
    // the wrong-path IF/ID instructions, then load-use inserts one bubble.
    always_comb begin
        stallRaw = 4'b0000;
        flushRaw = 3'b000;
        if (faultHold) begin
            stallRaw = 4'b1111;
        end else if (memHold) begin
            stallRaw    = 4'b1111;
            flushRaw[0] = 1'b1;
        end else if (hazardEval) begin
            if (ex_branch_taken) begin
                flushRaw[2] = 1'b1;
                flushRaw[1] = 1'b1;
            end else if (loadUse) begin
                stallRaw[3] = 1'b1;
                stallRaw[2] = 1'b1;
                flushRaw[1] = 1'b1;
            end
        end
    end

    // Outputs are held inactive for as long as reset is asserted.
    always_comb begin
        pc_stall     = stallRaw[3] && !rst;
        ifid_stall   = stallRaw[2] && !rst;
        idex_stall   = stallRaw[1] && !rst;
        exmem_stall  = stallRaw[0] && !rst;
        ifid_flush   = flushRaw[2] && !rst;
        idex_flush   = flushRaw[1] && !rst;
        memwb_flush  = flushRaw[0] && !rst;
        dram_req     = reqRaw && !rst;
        fault        = fault_q;
        stall_cycles = stallCnt_q;
    end

    // Stall-cycle counter advances on every held-PC cycle and sticks at all-ones.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (pc_stall && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_d = stallCnt_q + 16'd1;
        end
    end

    // State registers with asynchronous reset back to RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            waitCnt_q  <= '0;
            fault_q    <= 1'b0;
            stallCnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            fault_q    <= fault_d;
            stallCnt_q <= stallCnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl. The driver pushes the
// expected response from a cycle-level reference model; the monitor pops and
// compares once per cycle just before the rising edge.
module tb_pipe_ctrl;

    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] wR;
        logic       isLoad;
        logic       br;
        logic       memAcc;
        logic       ack;
    } stim_t;

    // flags: {pc,ifid,idex,exmem stall, ifid,idex,memwb flush, dram_req, fault}
    typedef struct {
        string       name;
        logic [8:0]  flags;
        logic [15:0] cnt;
    } sb_t;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_wR;
    logic        id_use_rs1, id_use_rs2, ex_is_load, ex_branch_taken;
    logic        mem_access, dram_ack;
    logic        pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic        ifid_flush, idex_flush, memwb_flush, dram_req, fault;
    logic [15:0] stall_cycles;

    sb_t sbQ[$];
    int  compared = 0;
    int  mismatched = 0;

    // Reference model state, in terms of the pipeline's observable behaviour.
    bit  mWaiting = 0;
    bit  mFaulted = 0;
    int  mSpent = 0;
    int  mStalls = 0;

    pipe_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_wR(ex_wR), .ex_is_load(ex_is_load),
        .ex_branch_taken(ex_branch_taken),
        .mem_access(mem_access), .dram_ack(dram_ack),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall),
        .idex_stall(idex_stall), .exmem_stall(exmem_stall),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_flush(memwb_flush), .dram_req(dram_req),
        .fault(fault), .stall_cycles(stall_cycles)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s.rst    = ($urandom_range(0, 63) == 0);
        s.rs1    = 5'($urandom_range(0, 3));
        s.rs2    = 5'($urandom_range(0, 3));
        s.use1   = 1'($urandom);
        s.use2   = 1'($urandom);
        s.wR     = 5'($urandom_range(0, 3));
        s.isLoad = 1'($urandom);
        s.br     = ($urandom_range(0, 3) == 0);
        s.memAcc = 1'($urandom);
        s.ack    = 1'($urandom);
        return s;
    endfunction

    // Drive one cycle of inputs, push the expected response, advance the model.
    task automatic applyStimulus(input string name, input stim_t s);
        sb_t e;
        bit  lu;
        bit  frozen;
        @(negedge clk);
        rst             = s.rst;
        id_rs1          = s.rs1;
        id_rs2          = s.rs2;
        id_use_rs1      = s.use1;
        id_use_rs2      = s.use2;
        ex_wR           = s.wR;
        ex_is_load      = s.isLoad;
        ex_branch_taken = s.br;
        mem_access      = s.memAcc;
        dram_ack        = s.ack;

        lu = s.isLoad && (s.wR != 0) &&
             ((s.use1 && s.rs1 == s.wR) || (s.use2 && s.rs2 == s.wR));
        frozen  = 0;
        e.name  = name;
        e.flags = '0;
        e.cnt   = '0;
        if (s.rst) begin
            mWaiting = 0;
            mFaulted = 0;
            mSpent   = 0;
            mStalls  = 0;
        end else begin
            e.cnt      = 16'(mStalls);
            e.flags[0] = mFaulted;
            if (mFaulted) begin
                e.flags[8:5] = 4'b1111;
            end else begin
                frozen = mWaiting ? !s.ack : (s.memAcc && !s.ack);
                if (frozen) begin
                    e.flags[8:5] = 4'b1111;
                    e.flags[2]   = 1'b1;
                    e.flags[1]   = 1'b1;
                end else begin
                    e.flags[1] = mWaiting || s.memAcc;
                    if (s.br) begin
                        e.flags[4] = 1'b1;
                        e.flags[3] = 1'b1;
                    end else if (lu) begin
                        e.flags[8] = 1'b1;
                        e.flags[7] = 1'b1;
                        e.flags[3] = 1'b1;
                    end
                end
            end
            if (e.flags[8] && mStalls < 65535) mStalls++;
            if (!mFaulted) begin
                if (frozen) begin
                    if (!mWaiting) begin
                        mWaiting = 1;
                        mSpent   = 0;
                    end else begin
                        mSpent++;
                        if (mSpent == TIMEOUT) begin
                            mFaulted = 1;
                            mWaiting = 0;
                        end
                    end
                end else begin
                    mWaiting = 0;
                end
            end
        end
        sbQ.push_back(e);
    endtask

    // Compare one scoreboard entry against what the DUT presents now.
    task automatic checkOutput(input sb_t e);
        logic [8:0] got;
        got = {pc_stall, ifid_stall, idex_stall, exmem_stall,
               ifid_flush, idex_flush, memwb_flush, dram_req, fault};
        compared++;
        if (got !== e.flags || stall_cycles !== e.cnt) begin
            mismatched++;
            $display("[TB] FAIL %s: got flags=%b stall_cycles=%h, required flags=%b stall_cycles=%h",
                     e.name, got, stall_cycles, e.flags, e.cnt);
        end
    endtask

    // Monitor: sample a little after each falling edge, once inputs settle.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbQ.size() != 0) begin
                e = sbQ.pop_front();
                checkOutput(e);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Stimulus sequence: directed cases, random traffic, then saturation.
    initial begin
        stim_t s;
        rst = 1'b1;
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_wR = '0; ex_is_load = 0; ex_branch_taken = 0;
        mem_access = 0; dram_ack = 0;

        s = idle(); s.rst = 1;
        for (int i = 0; i < 3; i++) applyStimulus("reset", s);
        for (int i = 0; i < 2; i++) applyStimulus("idle", idle());

        s = idle(); s.isLoad = 1; s.wR = 5; s.rs1 = 5; s.use1 = 1;
        applyStimulus("loaduse_rs1", s);
        applyStimulus("after_loaduse", idle());
        s.wR = 0; s.rs1 = 0;
        applyStimulus("loaduse_x0", s);
        s = idle(); s.isLoad = 1; s.wR = 7; s.rs2 = 7; s.use2 = 1;
        applyStimulus("loaduse_rs2", s);
        s.use2 = 0;
        applyStimulus("loaduse_unused", s);
        s = idle(); s.isLoad = 1; s.wR = 5; s.rs1 = 5; s.use1 = 1; s.br = 1;
        applyStimulus("branch_over_lu", s);
        applyStimulus("idle", idle());

        s = idle(); s.memAcc = 1; s.br = 1;
        for (int i = 0; i < 3; i++) applyStimulus("mem_wait", s);
        s.ack = 1;
        applyStimulus("mem_ack_branch", s);
        applyStimulus("after_ack", idle());

        s = idle(); s.memAcc = 1; s.ack = 1;
        applyStimulus("zero_wait", s);
        applyStimulus("after_zero_wait", idle());

        s = idle(); s.memAcc = 1;
        for (int i = 0; i < TIMEOUT + 4; i++) applyStimulus("timeout", s);
        s.ack = 1;
        for (int i = 0; i < 3; i++) applyStimulus("fault_ack_ignored", s);
        s = idle(); s.rst = 1;
        for (int i = 0; i < 2; i++) applyStimulus("fault_reset", s);
        applyStimulus("post_reset", idle());

        s = idle(); s.memAcc = 1;
        for (int i = 0; i < 4; i++) applyStimulus("wait_then_reset", s);
        s = idle(); s.rst = 1;
        applyStimulus("async_reset_wait", s);
        applyStimulus("post_reset", idle());

        for (int i = 0; i < 3000; i++) applyStimulus("random", randStim());

        s = idle(); s.rst = 1;
        applyStimulus("sat_reset", s);
        s = idle(); s.memAcc = 1;
        for (int i = 0; i < 65600; i++) applyStimulus("saturate", s);
        s = idle(); s.rst = 1;
        applyStimulus("sat_clear", s);
        applyStimulus("idle", idle());

        @(negedge clk);
        @(negedge clk);
        #3;
        compared++;
        if (sbQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending entries, required 0", sbQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum cycles spent in MEM_WAIT before fault.
REQ-002 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
REQ-005 SHALL have ports id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2.
REQ-006 SHALL have ports ex_wR (in, 5) and ex_is_load (in, 1)  destination register and load flag of the instruction in EX.
REQ-007 SHALL have port ex_branch_taken  in  1  EX resolved a taken branch/jump (PC redirect).
REQ-008 SHALL have port mem_access  in  1  instruction in EX/MEM register is a load or store needing DRAM.
REQ-009 SHALL have port dram_ack  in  1  DRAM access complete this cycle.
REQ-010 SHALL have ports pc_stall, ifid_stall, idex_stall, exmem_stall  out  1 each  hold the corresponding register.
REQ-011 SHALL have ports ifid_flush, idex_flush, memwb_flush  out  1 each  load a bubble (all-zero) into that register.
REQ-012 SHALL have port dram_req  out  1  DRAM access request.
REQ-013 SHALL have port fault  out  1  sticky memory-timeout error.
REQ-014 SHALL have port stall_cycles  out  16  count of cycles with pc_stall=1.

Function
REQ-015 SHALL implement states RUN, MEM_WAIT, FAULT; state, wait counter, fault and stall_cycles registered; stall/flush/dram_req outputs combinational from state and inputs.
REQ-016 SHALL define lu = ex_is_load & (ex_wR!=0) & ((id_use_rs1 & id_rs1==ex_wR) | (id_use_rs2 & id_rs2==ex_wR)).
REQ-017 SHALL define mw = mem_access & ~dram_ack; priority mw > ex_branch_taken > lu.
REQ-018 RUN, mw=1: dram_req=1; pc/ifid/idex/exmem stall=1; memwb_flush=1; all other flushes 0; next state MEM_WAIT, wait counter cleared to 0.
REQ-019 RUN, mem_access=1 and dram_ack=1 same cycle: dram_req=1, zero-wait access, no stall from memory; remaining terms evaluated normally.
REQ-020 RUN, mw=0, ex_branch_taken=1: ifid_flush=1, idex_flush=1, no stalls; lu ignored (ID instruction is wrong-path).
REQ-021 RUN, mw=0, ex_branch_taken=0, lu=1: pc_stall=1, ifid_stall=1, idex_flush=1; exactly one bubble; no state change.
REQ-022 RUN, no term active: all stall/flush outputs 0.
REQ-023 MEM_WAIT, dram_ack=0: same outputs as REQ-018; wait counter increments by 1 per cycle.
REQ-024 MEM_WAIT, dram_ack=1: dram_req=1, memory stalls and memwb_flush deasserted that cycle; branch/lu evaluated as in RUN (REQ-020..022); next state RUN.
REQ-025 MEM_WAIT, counter reaches TIMEOUT-1 with dram_ack=0: next state FAULT (TIMEOUT cycles total spent in MEM_WAIT).
REQ-026 FAULT: all four stalls=1, all flushes=0, dram_req=0, fault=1; exits only on rst; dram_ack ignored.
REQ-027 A branch taken during MEM_WAIT SHALL be held (pipeline frozen) and acted on in the ack cycle.
REQ-028 stall_cycles SHALL increment each cycle pc_stall=1, saturating at 16'hFFFF (no wrap).

Reset
REQ-029 While rst=1: state RUN, wait counter 0, fault 0, stall_cycles 0, and all stall/flush/dram_req outputs forced 0 regardless of inputs.
REQ-030 rst asserted in MEM_WAIT or FAULT SHALL return to RUN asynchronously; first post-reset cycle behaves per RUN.

Verification
REQ-031 Load-use: ex_is_load=1, ex_wR=5, id_rs1=5, id_use_rs1=1 -> one cycle pc_stall=ifid_stall=idex_flush=1; ex_wR=0 same case -> no stall.
REQ-032 Branch+load-use same cycle: ex_branch_taken=1, lu=1 -> ifid_flush=idex_flush=1, pc_stall=0, stall_cycles unchanged.
REQ-033 Memory wait: mem_access=1, dram_ack low 3 cycles then high -> 3 cycles of four stalls+memwb_flush, ack cycle no stall, stall_cycles +3.
REQ-034 Zero-wait: mem_access=1, dram_ack=1 same cycle -> dram_req=1, no stall, state stays RUN.
REQ-035 Timeout: mem_access=1, dram_ack=0 forever -> fault=1 after 16 cycles in MEM_WAIT, dram_req=0; later dram_ack=1 ignored; rst clears fault to 0.
REQ-036 Saturation: force 70000 stall cycles -> stall_cycles holds 16'hFFFF.
